// File: rtl/psum_buffer_a2.sv
// psum_buffer_a2
// Partial-sum buffer and pass sequencer for the A2 convolution layer. Sits after the A2
// accumulator and closes its feedback loop: each accumulated pixel is stored and replayed
// on the next channel pass through psum_data_out, while accu_enable selects bias (first
// pass) or the stored partial sum (later passes). On the final pass finished pixels are
// streamed out on the OFM port instead of being stored.
//
// Optional feature macro: PSUM_RELU_EN -- when defined, final-pass outputs are ReLU'd
// (negative sign bit forces ofm_data_out to zero). Stored partial sums are never ReLU'd.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   start          in   begin a filter (sampled only in IDLE)
//   conv_valid     in   accu_data_in valid this cycle (used only in ACCUM)
//   accu_data_in   in   accumulator result
//   accu_enable    out  0 = bias, 1 = stored partial sum
//   psum_data_out  out  stored partial sum at the current address (asynchronous read)
//   ofm_data_out   out  finished pixel
//   ofm_address    out  pixel index of ofm_data_out
//   ofm_valid      out  OFM data/address valid
//   busy           out  high while accumulating
//   done           out  one-cycle pulse when a filter completes
module psum_buffer_a2 #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned IFM_SIZE         = 14,
    parameter int unsigned KERNAL_SIZE      = 5,
    parameter int unsigned NUMBER_OF_PASSES = 2,
    parameter int unsigned OFM_PIXELS       = (IFM_SIZE - KERNAL_SIZE + 1) ** 2,
    parameter int unsigned ADDRESS_SIZE     = $clog2(OFM_PIXELS),
    parameter int unsigned PASS_BITS        = $clog2(NUMBER_OF_PASSES) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    conv_valid,
    input  logic [DATA_WIDTH-1:0]   accu_data_in,
    output logic                    accu_enable,
    output logic [DATA_WIDTH-1:0]   psum_data_out,
    output logic [DATA_WIDTH-1:0]   ofm_data_out,
    output logic [ADDRESS_SIZE-1:0] ofm_address,
    output logic                    ofm_valid,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDRESS_SIZE-1:0] LastAddr = ADDRESS_SIZE'(OFM_PIXELS - 1);
    localparam logic [PASS_BITS-1:0]    LastPass = PASS_BITS'(NUMBER_OF_PASSES - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [PASS_BITS-1:0]    pass_q, pass_d;
    logic [DATA_WIDTH-1:0]   ofm_data_q, ofm_data_d;
    logic [ADDRESS_SIZE-1:0] ofm_addr_q, ofm_addr_d;
    logic                    ofm_valid_q, ofm_valid_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   out_data;

    // Partial-sum storage; deliberately not reset.
    logic [DATA_WIDTH-1:0]   mem_q [OFM_PIXELS];

    logic consume, final_pass, last_addr, filter_end;

    assign consume    = (state_q == StAccum) && conv_valid;
    assign final_pass = (pass_q == LastPass);
    assign last_addr  = (addr_q == LastAddr);
    assign filter_end = consume && final_pass && last_addr;

`ifdef PSUM_RELU_EN
    assign out_data = accu_data_in[DATA_WIDTH-1] ? '0 : accu_data_in;
`else
    assign out_data = accu_data_in;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StAccum;
            StAccum: if (filter_end) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy        = (state_q == StAccum);
        done        = (state_q == StDone);
        accu_enable = (state_q == StAccum) && (pass_q != '0);
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        addr_d      = addr_q;
        pass_d      = pass_q;
        ofm_data_d  = ofm_data_q;
        ofm_addr_d  = ofm_addr_q;
        ofm_valid_d = 1'b0;
        mem_we      = 1'b0;

        if ((state_q == StIdle) && start) begin
            addr_d = '0;
            pass_d = '0;
        end

        if (consume) begin
            if (final_pass) begin
                ofm_valid_d = 1'b1;
                ofm_data_d  = out_data;
                ofm_addr_d  = addr_q;
            end else begin
                mem_we = 1'b1;
            end

            if (last_addr) begin
                addr_d = '0;
                // The final wrap ends the filter, so park the pass counter at zero.
                pass_d = final_pass ? '0 : pass_q + 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            pass_q      <= '0;
            ofm_data_q  <= '0;
            ofm_addr_q  <= '0;
            ofm_valid_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            ofm_data_q  <= ofm_data_d;
            ofm_addr_q  <= ofm_addr_d;
            ofm_valid_q <= ofm_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[addr_q] <= accu_data_in;
        end
    end

    // Asynchronous read so the accumulator loop closes in the same cycle.
    assign psum_data_out = mem_q[addr_q];
    assign ofm_data_out  = ofm_data_q;
    assign ofm_address   = ofm_addr_q;
    assign ofm_valid     = ofm_valid_q;

endmodule

// File: tb/tb_psum_buffer_a2.sv
module tb_psum_buffer_a2;

    logic        clk = 1'b0;
    logic        reset, start, conv_valid;
    logic [31:0] accu_data_in;
    logic        accu_enable, ofm_valid, busy, done;
    logic [31:0] psum_data_out, ofm_data_out;
    logic [6:0]  ofm_address;

    // Single-pass instance
    logic        start1, cv1;
    logic [31:0] data1;
    logic        acc_en1, ofm_valid1, busy1, done1;
    logic [31:0] psum1, ofm_data1;
    logic [6:0]  ofm_addr1;

    int checks = 0;
    int errors = 0;
    int ofm_cnt0 = 0;
    int ofm_cnt1 = 0;
    logic [38:0] sb0[$];
    logic [38:0] sb1[$];

    always #5 clk = ~clk;

    psum_buffer_a2 dut (
        .clk(clk), .reset(reset), .start(start), .conv_valid(conv_valid),
        .accu_data_in(accu_data_in), .accu_enable(accu_enable),
        .psum_data_out(psum_data_out), .ofm_data_out(ofm_data_out),
        .ofm_address(ofm_address), .ofm_valid(ofm_valid), .busy(busy), .done(done)
    );

    psum_buffer_a2 #(.NUMBER_OF_PASSES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .conv_valid(cv1),
        .accu_data_in(data1), .accu_enable(acc_en1),
        .psum_data_out(psum1), .ofm_data_out(ofm_data1),
        .ofm_address(ofm_addr1), .ofm_valid(ofm_valid1), .busy(busy1), .done(done1)
    );

    function automatic logic [31:0] itof(int unsigned n);
        int e;
        if (n == 0) return 32'h0;
        e = 31;
        while (n[e] == 1'b0) e--;
        return {1'b0, 8'(127 + e), 23'(n << (23 - e))};
    endfunction

    function automatic logic [31:0] relu_exp(logic [31:0] d);
`ifdef PSUM_RELU_EN
        return d[31] ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any OFM output against the scoreboards.
    task automatic tick();
        logic [38:0] e;
        @(posedge clk);
        #1;
        if (ofm_valid) begin
            if (sb0.size() == 0) begin
                check("ofm_unexpected", 32'(ofm_valid), 32'h0);
            end else begin
                e = sb0.pop_front();
                check("ofm_addr", 32'(ofm_address), 32'(e[38:32]));
                check("ofm_data", ofm_data_out, e[31:0]);
                ofm_cnt0++;
            end
        end
        if (ofm_valid1) begin
            if (sb1.size() == 0) begin
                check("ofm1_unexpected", 32'(ofm_valid1), 32'h0);
            end else begin
                e = sb1.pop_front();
                check("ofm1_addr", 32'(ofm_addr1), 32'(e[38:32]));
                check("ofm1_data", ofm_data1, e[31:0]);
                ofm_cnt1++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; conv_valid = 1'b0; accu_data_in = '0;
        start1 = 1'b0; cv1 = 1'b0; data1 = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_acc_en", 32'(accu_enable), 32'h0);
        check("rst_ofm_valid", 32'(ofm_valid), 32'h0);
        check("rst_ofm_data", ofm_data_out, 32'h0);
        check("rst_ofm_addr", 32'(ofm_address), 32'h0);
        reset = 1'b0;

        // Back-to-back: 200 valids, pixel i = i as float
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_start", 32'(busy), 32'h1);
        for (int i = 0; i < 200; i++) begin
            conv_valid   = 1'b1;
            accu_data_in = itof(i);
            if (i < 100) begin
                check("t1_acc_en_p0", 32'(accu_enable), 32'h0);
            end else begin
                check("t1_acc_en_p1", 32'(accu_enable), 32'h1);
                check("t1_psum", psum_data_out, itof(i - 100));
                sb0.push_back({7'(i - 100), itof(i)});
            end
            tick();
            if (i == 198) check("t1_done_early", 32'(done), 32'h0);
        end
        conv_valid = 1'b0;
        check("t1_done", 32'(done), 32'h1);
        check("t1_busy_at_done", 32'(busy), 32'h0);
        tick();
        check("t1_done_pulse", 32'(done), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_ofm_count", 32'(ofm_cnt0), 32'd100);
        check("t1_sb_drain", 32'(sb0.size()), 32'h0);

        // Alternating valid gaps, with ReLU probes on the final pass
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int p;
            logic [31:0] d;
            p = i / 2;
            if (i % 2 == 1) begin
                conv_valid   = 1'b0;
                accu_data_in = 32'hFFFF_FFFF;
            end else begin
                conv_valid = 1'b1;
                if (p < 100) begin
                    d = itof(1000 + p);
                end else begin
                    d = (p == 105) ? 32'hC000_0000 :
                        (p == 106) ? 32'h3F80_0000 : itof(2000 + p);
                    check("t2_psum", psum_data_out, itof(1000 + p - 100));
                    sb0.push_back({7'(p - 100), relu_exp(d)});
                end
                accu_data_in = d;
            end
            tick();
            if (i == 200) check("t2_busy", 32'(busy), 32'h1);
            if (i == 396) check("t2_done_early", 32'(done), 32'h0);
            if (i == 398) check("t2_done", 32'(done), 32'h1);
        end
        conv_valid = 1'b0;
        check("t2_ofm_count", 32'(ofm_cnt0), 32'd200);
        check("t2_sb_drain", 32'(sb0.size()), 32'h0);

        // Reset after 37 pass-0 valids
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 37; i++) begin
            conv_valid   = 1'b1;
            accu_data_in = itof(3000 + i);
            tick();
        end
        conv_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t3_busy", 32'(busy), 32'h0);
        check("t3_acc_en", 32'(accu_enable), 32'h0);
        check("t3_ofm_valid", 32'(ofm_valid), 32'h0);
        check("t3_done", 32'(done), 32'h0);
        check("t3_psum_addr0", psum_data_out, itof(3000));

        // conv_valid in IDLE must neither write nor emit
        conv_valid   = 1'b1;
        accu_data_in = 32'hDEAD_BEEF;
        tick();
        conv_valid = 1'b0;
        check("t3_idle_nowrite", psum_data_out, itof(3000));
        check("t3_idle_busy", 32'(busy), 32'h0);

        // Restart from addr 0 / pass 0, with a stray start pulse mid-ACCUM
        start = 1'b1;
        tick();
        for (int i = 0; i < 200; i++) begin
            start        = (i == 50);
            conv_valid   = 1'b1;
            if (i < 100) begin
                accu_data_in = itof(4000 + i);
                check("t3_acc_en_p0", 32'(accu_enable), 32'h0);
            end else begin
                accu_data_in = itof(5000 + i);
                check("t3_acc_en_p1", 32'(accu_enable), 32'h1);
                check("t3_psum", psum_data_out, itof(4000 + i - 100));
                sb0.push_back({7'(i - 100), itof(5000 + i)});
            end
            tick();
        end
        start = 1'b0;
        conv_valid = 1'b0;
        check("t3_done", 32'(done), 32'h1);
        tick();
        check("t3_done_pulse", 32'(done), 32'h0);
        check("t3_sb_drain", 32'(sb0.size()), 32'h0);

        // Single-pass configuration
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t4_busy", 32'(busy1), 32'h1);
        for (int i = 0; i < 100; i++) begin
            cv1   = 1'b1;
            data1 = itof(6000 + i);
            check("t4_acc_en", 32'(acc_en1), 32'h0);
            sb1.push_back({7'(i), itof(6000 + i)});
            tick();
            if (i == 98) check("t4_done_early", 32'(done1), 32'h0);
        end
        cv1 = 1'b0;
        check("t4_done", 32'(done1), 32'h1);
        check("t4_busy_at_done", 32'(busy1), 32'h0);
        check("t4_acc_en_done", 32'(acc_en1), 32'h0);
        tick();
        check("t4_done_pulse", 32'(done1), 32'h0);
        check("t4_ofm_count", 32'(ofm_cnt1), 32'd100);
        check("t4_sb_drain", 32'(sb1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
